cpu_dump_controller: RTL

CPU_DUMP_CONTROLLER -- requirements
Module: cpu_dump_controller

---
 rtl/cpu_dump_controller.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cpu_dump_controller.sv
// CPU run/dump sequencer: lets the CPU run for a programmed number of cycles,
// then streams the register file followed by data memory over a valid/ready port.
module cpu_dump_controller #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_AW    = 5,
  parameter int MEM_WORDS = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  run_cycles,
  output logic              cpu_en,
  output logic [REG_AW-1:0] dbg_reg_a,
  input  logic [DATA_W-1:0] dbg_reg_rd,
  output logic [31:0]       dbg_mem_a,
  input  logic [DATA_W-1:0] dbg_mem_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kind,
  output logic [CNT_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Pointer is kept 32 bits wide so the memory byte address can be formed directly.
  localparam logic [31:0] REG_LIM = 32'(REG_COUNT);
  localparam logic [31:0] TOTAL   = 32'(REG_COUNT + MEM_WORDS);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         ptr_q;
  logic                cpu_en_q;
  logic                out_valid_q;
  logic                out_kind_q;
  logic [CNT_W-1:0]    out_index_q;
  logic [DATA_W-1:0]   out_data_q;

  logic                in_range_s;
  logic                is_reg_s;
  logic [31:0]         mem_off_s;
  logic                fetch_kind_s;
  logic [CNT_W-1:0]    fetch_index_s;
  logic [DATA_W-1:0]   fetch_data_s;
  logic                load_s;
  logic                xfer_s;

  // Decode the fetch pointer into a register or memory word and its metadata.
  always_comb begin
    is_reg_s   = (ptr_q < REG_LIM);
    mem_off_s  = ptr_q - REG_LIM;
    in_range_s = (state_q == ST_DUMP) && (ptr_q < TOTAL);
    fetch_kind_s = ~is_reg_s;
    if (is_reg_s) begin
      fetch_index_s = CNT_W'(ptr_q);
      fetch_data_s  = dbg_reg_rd;
    end else begin
      fetch_index_s = CNT_W'(mem_off_s);
      fetch_data_s  = dbg_mem_rd;
    end
  end

  // Drive the debug read addresses; the port not being read stays at zero.
  always_comb begin
    dbg_reg_a = '0;
    dbg_mem_a = 32'd0;
    if (in_range_s && is_reg_s) begin
      dbg_reg_a = REG_AW'(ptr_q);
    end else if (in_range_s) begin
      dbg_mem_a = mem_off_s << 2'd2;
    end else begin
      dbg_reg_a = '0;
      dbg_mem_a = 32'd0;
    end
  end

  // Output register can accept a new word when empty or being drained this edge.
  always_comb begin
    load_s = in_range_s && (!out_valid_q || out_ready);
    xfer_s = out_valid_q && out_ready;
  end

  // Main sequencer: run countdown, dump walk and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ptr_q       <= 32'd0;
      cpu_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_kind_q  <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cnt_q       <= run_cycles;
            ptr_q       <= 32'd0;
            out_valid_q <= 1'b0;
            if (run_cycles == '0) begin
              state_q  <= ST_DUMP;
              cpu_en_q <= 1'b0;
            end else begin
              state_q  <= ST_RUN;
              cpu_en_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q  <= ST_IDLE;
            cpu_en_q <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= 32'd0;
          end else if (cnt_q <= CNT_W'(1)) begin
            // Last enabled cycle: count reaches zero on this edge.
            state_q  <= ST_DUMP;
            cpu_en_q <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= 32'd0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DUMP: begin
          if (abort) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 32'd0;
            out_valid_q <= 1'b0;
            out_kind_q  <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
          end else if (load_s) begin
            out_valid_q <= 1'b1;
            out_kind_q  <= fetch_kind_s;
            out_index_q <= fetch_index_s;
            out_data_q  <= fetch_data_s;
            ptr_q       <= ptr_q + 32'd1;
          end else if (xfer_s) begin
            out_valid_q <= 1'b0;
            // Pointer exhausted means the word just taken was the final memory word.
            if (ptr_q == TOTAL) begin
              state_q <= ST_DONE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cpu_en_q    <= 1'b0;
          out_valid_q <= 1'b0;
          ptr_q       <= 32'd0;
        end
      endcase
    end
  end

  assign cpu_en    = cpu_en_q;
  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DUMP);
  assign done      = (state_q == ST_DONE);

endmodule
